router_terminal_port: RTL and testbench

//  Terminal-side endpoint for one port of router_bus_gnrtr; the RTL counterpart of the bench driver/monitor.
//  TX path: buffers host packets and presents them to the router's input handshake (pndng_i_in/data_out_i_in/popin).
//  RX path: accepts router output pushes (push/data_out), filters them by destination ID and buffers them for the host.

---
 rtl/router_terminal_port.sv | 152 +++++++++++++++
 tb/tb_router_terminal_port.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_terminal_port.sv
// router_terminal_port: terminal-side endpoint for one router port.
//   TX path: host packets (tx_data/tx_valid/tx_ready) are buffered and offered
//            to the router as a show-ahead head (pndng_i_in/data_out_i_in/popin).
//   RX path: router pushes (push/data_out) are filtered on destination ID
//            (MY_ID or BROADCAST) and buffered for the host (rx_data/rx_valid/rx_ready).
//   Error counters (saturating): misroute_cnt, overflow_cnt, underflow_cnt.
//   Packet layout: [PCKG_SZ-1 -: 8] destination ID, remaining bits payload.
// Every output is driven from registered state only.

// router_terminal_port_fifo: show-ahead FIFO with a registered head.
//   clk_i/rst_ni   clock, async active-low reset
//   wr_i/wdata_i   write request (ignored when full)
//   rd_i           pop request (ignored when empty)
//   full_o/empty_o status from registered pointers
//   head_o         registered head; keeps its last value while empty
module router_terminal_port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wptr_q, wptr_d;
  ptr_t             rptr_q, rptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             wr_en, rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign wr_en   = wr_i && !full_o;
  assign rd_en   = rd_i && !empty_o;
  assign head_o  = head_q;

  always_comb begin
    wptr_d = wptr_q + (wr_en ? ptr_t'(1) : ptr_t'(0));
    rptr_d = rptr_q + (rd_en ? ptr_t'(1) : ptr_t'(0));
    head_d = head_q;
    if (wptr_d != rptr_d) begin
      // The incoming word becomes the head when it lands in the slot the
      // read pointer will point at (FIFO empty, or last entry popped now).
      if (wr_en && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) head_d = wdata_i;
      else                                              head_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
    end
  end

  // Storage needs no reset: contents are only visible through head_q.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

module router_terminal_port #(
  parameter int         PCKG_SZ    = 16,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] MY_ID      = 8'h00,
  parameter logic [7:0] BROADCAST  = 8'hFF,
  parameter int         CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PCKG_SZ-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               pndng_i_in,
  output logic [PCKG_SZ-1:0] data_out_i_in,
  input  logic               popin,
  input  logic               push,
  input  logic [PCKG_SZ-1:0] data_out,
  output logic [PCKG_SZ-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [CNT_W-1:0]   misroute_cnt,
  output logic [CNT_W-1:0]   overflow_cnt,
  output logic [CNT_W-1:0]   underflow_cnt
);
  logic       tx_full, tx_empty;
  logic       rx_full, rx_empty;
  logic [7:0] rx_id;
  logic       rx_acc;
  logic [CNT_W-1:0] misroute_q, overflow_q, underflow_q;

  router_terminal_port_fifo #(.WIDTH(PCKG_SZ), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .wr_i    (tx_valid),
    .wdata_i (tx_data),
    .rd_i    (popin),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (data_out_i_in)
  );

  assign rx_id  = data_out[PCKG_SZ-1 -: 8];
  assign rx_acc = (rx_id == MY_ID) || (rx_id == BROADCAST);

  router_terminal_port_fifo #(.WIDTH(PCKG_SZ), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .wr_i    (push && rx_acc),
    .wdata_i (data_out),
    .rd_i    (rx_ready),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_data)
  );

  assign tx_ready   = !tx_full;
  assign pndng_i_in = !tx_empty;
  assign rx_valid   = !rx_empty;

  // Counters stick at all-ones; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misroute_q  <= '0;
      overflow_q  <= '0;
      underflow_q <= '0;
    end else begin
      if (push && !rx_acc && (misroute_q != {CNT_W{1'b1}}))
        misroute_q <= misroute_q + CNT_W'(1);
      if (push && rx_acc && rx_full && (overflow_q != {CNT_W{1'b1}}))
        overflow_q <= overflow_q + CNT_W'(1);
      if (popin && tx_empty && (underflow_q != {CNT_W{1'b1}}))
        underflow_q <= underflow_q + CNT_W'(1);
    end
  end

  assign misroute_cnt  = misroute_q;
  assign overflow_cnt  = overflow_q;
  assign underflow_cnt = underflow_q;
endmodule

// File: tb/tb_router_terminal_port.sv
module tb_router_terminal_port;
  localparam int         D  = 16;
  localparam logic [7:0] MY = 8'h0A;
  localparam logic [7:0] BC = 8'hFF;

  logic        clk, reset;
  logic [15:0] tx_data, data_out;
  logic        tx_valid, popin, push, rx_ready;
  logic        tx_ready, pndng_i_in, rx_valid;
  logic [15:0] data_out_i_in, rx_data;
  logic [15:0] misroute_cnt, overflow_cnt, underflow_cnt;

  // small-counter instance used for the saturation check
  logic        sat_popin, s_zero;
  logic [15:0] s_zero16;
  logic        s_tx_ready, s_pndng, s_rx_valid;
  logic [15:0] s_head, s_rx_data;
  logic [3:0]  s_mis, s_ovf, s_und;

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  logic [15:0] mq_tx[$];
  logic [15:0] mq_rx[$];
  logic [15:0] m_tx_last;
  int m_mis, m_ovf, m_und, m_sat;

  router_terminal_port #(.MY_ID(MY), .BROADCAST(BC)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin), .push(push),
    .data_out(data_out), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .misroute_cnt(misroute_cnt), .overflow_cnt(overflow_cnt), .underflow_cnt(underflow_cnt)
  );

  router_terminal_port #(.MY_ID(MY), .BROADCAST(BC), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .tx_data(s_zero16), .tx_valid(s_zero), .tx_ready(s_tx_ready),
    .pndng_i_in(s_pndng), .data_out_i_in(s_head), .popin(sat_popin), .push(s_zero),
    .data_out(s_zero16), .rx_data(s_rx_data), .rx_valid(s_rx_valid), .rx_ready(s_zero),
    .misroute_cnt(s_mis), .overflow_cnt(s_ovf), .underflow_cnt(s_und)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    tx_valid = 0; popin = 0; push = 0; rx_ready = 0; sat_popin = 0;
    tx_data = '0; data_out = '0;
  endtask

  task automatic model_reset();
    mq_tx.delete(); mq_rx.delete();
    m_tx_last = '0; m_mis = 0; m_ovf = 0; m_und = 0; m_sat = 0;
  endtask

  // one clock: advance the reference model on the inputs sampled at the edge
  task automatic step();
    int txn, rxn;
    logic [7:0] id;
    @(posedge clk);
    txn = mq_tx.size();
    rxn = mq_rx.size();
    if (popin && txn == 0 && m_und < 65535) m_und++;
    if (popin && txn > 0) void'(mq_tx.pop_front());
    if (tx_valid && txn < D) mq_tx.push_back(tx_data);
    if (mq_tx.size() > 0) m_tx_last = mq_tx[0];
    if (rx_ready && rxn > 0) void'(mq_rx.pop_front());
    if (push) begin
      id = data_out[15:8];
      if (id == MY || id == BC) begin
        if (rxn < D) mq_rx.push_back(data_out);
        else if (m_ovf < 65535) m_ovf++;
      end else if (m_mis < 65535) m_mis++;
    end
    if (sat_popin && m_sat < 15) m_sat++;
    #1;
  endtask

  task automatic test_reset();
    reset = 0; idle(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (tx_ready !== 1'b1)      begin n_err++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (pndng_i_in !== 1'b0)    begin n_err++; $display("FAIL reset_pndng: got %b want 0", pndng_i_in); end
    n_cmp++; if (data_out_i_in !== 16'h0) begin n_err++; $display("FAIL reset_head: got %h want 0000", data_out_i_in); end
    n_cmp++; if (rx_valid !== 1'b0)      begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 16'h0)      begin n_err++; $display("FAIL reset_rx_data: got %h want 0000", rx_data); end
    n_cmp++; if ({misroute_cnt, overflow_cnt, underflow_cnt} !== 48'h0)
      begin n_err++; $display("FAIL reset_counters: got %h/%h/%h want 0", misroute_cnt, overflow_cnt, underflow_cnt); end
    reset = 1;
    step();
  endtask

  task automatic test_loopback();
    tx_data = 16'h0A55; tx_valid = 1; step(); idle();
    n_cmp++; if (pndng_i_in !== 1'b1)       begin n_err++; $display("FAIL loop_pndng_rise: got %b want 1", pndng_i_in); end
    n_cmp++; if (data_out_i_in !== 16'h0A55) begin n_err++; $display("FAIL loop_head: got %h want 0a55", data_out_i_in); end
    step();
    n_cmp++; if (data_out_i_in !== 16'h0A55) begin n_err++; $display("FAIL loop_head_stable: got %h want 0a55", data_out_i_in); end
    popin = 1; step(); idle();
    n_cmp++; if (pndng_i_in !== 1'b0)       begin n_err++; $display("FAIL loop_pndng_fall: got %b want 0", pndng_i_in); end
    n_cmp++; if (data_out_i_in !== 16'h0A55) begin n_err++; $display("FAIL loop_head_hold: got %h want 0a55", data_out_i_in); end
    push = 1; data_out = 16'h0A55; step(); idle();
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 16'h0A55)
      begin n_err++; $display("FAIL loop_rx: got %b/%h want 1/0a55", rx_valid, rx_data); end
    rx_ready = 1; step(); idle();
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL loop_rx_empty: got %b want 0", rx_valid); end
  endtask

  task automatic test_tx_full();
    logic [15:0] exp[D];
    for (int i = 0; i < D; i++) begin
      exp[i] = 16'($urandom);
      tx_data = exp[i]; tx_valid = 1; step();
    end
    idle();
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL full_tx_ready: got %b want 0", tx_ready); end
    tx_data = 16'hDEAD; tx_valid = 1; step();
    // write while full with a same-cycle pop: pop honoured, write dropped
    tx_data = 16'hBEEF; popin = 1; step(); idle();
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL full_after_pop_ready: got %b want 1", tx_ready); end
    for (int i = 1; i < D; i++) begin
      n_cmp++; if (data_out_i_in !== exp[i] || pndng_i_in !== 1'b1)
        begin n_err++; $display("FAIL full_order[%0d]: got %h/%b want %h/1", i, data_out_i_in, pndng_i_in, exp[i]); end
      popin = 1; step();
    end
    idle();
    n_cmp++; if (pndng_i_in !== 1'b0) begin n_err++; $display("FAIL full_drained: got %b want 0", pndng_i_in); end
    n_cmp++; if (underflow_cnt !== 16'd0) begin n_err++; $display("FAIL full_underflow: got %0d want 0", underflow_cnt); end
  endtask

  task automatic test_rx_filter();
    push = 1; data_out = {MY, 8'hAB}; step();
    data_out = 16'hFF12; step();
    data_out = 16'h0533; step(); idle();
    n_cmp++; if (misroute_cnt !== 16'd1) begin n_err++; $display("FAIL filt_misroute: got %0d want 1", misroute_cnt); end
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== {MY, 8'hAB})
      begin n_err++; $display("FAIL filt_first: got %b/%h want 1/%h", rx_valid, rx_data, {MY, 8'hAB}); end
    rx_ready = 1; step();
    n_cmp++; if (rx_data !== 16'hFF12) begin n_err++; $display("FAIL filt_bcast: got %h want ff12", rx_data); end
    step(); idle();
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL filt_empty: got %b want 0", rx_valid); end
  endtask

  task automatic test_rx_overflow();
    logic [15:0] exp[D];
    push = 1;
    for (int i = 0; i < D + 1; i++) begin
      data_out = {(i % 2 == 0) ? MY : BC, 8'($urandom)};
      if (i < D) exp[i] = data_out;
      step();
    end
    idle();
    n_cmp++; if (overflow_cnt !== 16'd1) begin n_err++; $display("FAIL ovf_first: got %0d want 1", overflow_cnt); end
    push = 1; data_out = 16'h3377; step(); idle();
    n_cmp++; if (misroute_cnt !== 16'd2 || overflow_cnt !== 16'd1)
      begin n_err++; $display("FAIL ovf_misroute_full: got %0d/%0d want 2/1", misroute_cnt, overflow_cnt); end
    push = 1; rx_ready = 1; data_out = {MY, 8'h99}; step(); idle();
    n_cmp++; if (overflow_cnt !== 16'd2) begin n_err++; $display("FAIL ovf_same_cycle_pop: got %0d want 2", overflow_cnt); end
    for (int i = 1; i < D; i++) begin
      n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp[i])
        begin n_err++; $display("FAIL ovf_order[%0d]: got %b/%h want 1/%h", i, rx_valid, rx_data, exp[i]); end
      rx_ready = 1; step();
    end
    idle();
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %b want 0", rx_valid); end
  endtask

  task automatic test_underflow_sat();
    for (int i = 0; i < 3; i++) begin popin = 1; step(); end
    idle();
    n_cmp++; if (underflow_cnt !== 16'd3) begin n_err++; $display("FAIL und_three: got %0d want 3", underflow_cnt); end
    for (int i = 1; i <= 20; i++) begin
      sat_popin = 1; step();
      n_cmp++; if (s_und !== 4'(m_sat))
        begin n_err++; $display("FAIL sat_step[%0d]: got %0d want %0d", i, s_und, m_sat); end
    end
    idle();
    n_cmp++; if (s_und !== 4'hF) begin n_err++; $display("FAIL sat_hold: got %h want f", s_und); end
  endtask

  task automatic test_random();
    logic [7:0] id;
    for (int c = 0; c < 400; c++) begin
      tx_valid = ($urandom_range(0, 9) < ((c < 200) ? 7 : 3));
      tx_data  = 16'($urandom);
      popin    = ($urandom_range(0, 9) < ((c < 200) ? 3 : 7));
      push     = ($urandom_range(0, 9) < ((c < 200) ? 7 : 3));
      case ($urandom_range(0, 3))
        0, 1: id = MY;
        2:    id = BC;
        default: id = 8'($urandom);
      endcase
      data_out = {id, 8'($urandom)};
      rx_ready = ($urandom_range(0, 9) < ((c < 200) ? 3 : 7));
      step();
      n_cmp++; if (tx_ready !== (mq_tx.size() < D))
        begin n_err++; $display("FAIL rnd_tx_ready c%0d: got %b want %b", c, tx_ready, mq_tx.size() < D); end
      n_cmp++; if (pndng_i_in !== (mq_tx.size() > 0))
        begin n_err++; $display("FAIL rnd_pndng c%0d: got %b want %b", c, pndng_i_in, mq_tx.size() > 0); end
      n_cmp++; if (data_out_i_in !== m_tx_last)
        begin n_err++; $display("FAIL rnd_head c%0d: got %h want %h", c, data_out_i_in, m_tx_last); end
      n_cmp++; if (rx_valid !== (mq_rx.size() > 0))
        begin n_err++; $display("FAIL rnd_rx_valid c%0d: got %b want %b", c, rx_valid, mq_rx.size() > 0); end
      if (mq_rx.size() > 0) begin
        n_cmp++; if (rx_data !== mq_rx[0])
          begin n_err++; $display("FAIL rnd_rx_data c%0d: got %h want %h", c, rx_data, mq_rx[0]); end
      end
      n_cmp++; if (misroute_cnt !== 16'(m_mis) || overflow_cnt !== 16'(m_ovf) || underflow_cnt !== 16'(m_und))
        begin n_err++; $display("FAIL rnd_counters c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                                misroute_cnt, overflow_cnt, underflow_cnt, m_mis, m_ovf, m_und); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1; tx_data = 16'h1000 + 16'(i);
      push = 1; data_out = {BC, 8'(i)};
      step();
    end
    idle();
    #3 reset = 0;
    #1;
    model_reset();
    n_cmp++; if (tx_ready !== 1'b1 || pndng_i_in !== 1'b0 || data_out_i_in !== 16'h0)
      begin n_err++; $display("FAIL mid_tx: got %b/%b/%h want 1/0/0000", tx_ready, pndng_i_in, data_out_i_in); end
    n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 16'h0)
      begin n_err++; $display("FAIL mid_rx: got %b/%h want 0/0000", rx_valid, rx_data); end
    n_cmp++; if ({misroute_cnt, overflow_cnt, underflow_cnt} !== 48'h0 || s_und !== 4'h0)
      begin n_err++; $display("FAIL mid_counters: got %h/%h/%h/%h want 0", misroute_cnt, overflow_cnt, underflow_cnt, s_und); end
    @(negedge clk);
    reset = 1;
    tx_valid = 1; tx_data = 16'h0A77; step(); idle();
    n_cmp++; if (pndng_i_in !== 1'b1 || data_out_i_in !== 16'h0A77)
      begin n_err++; $display("FAIL mid_restart: got %b/%h want 1/0a77", pndng_i_in, data_out_i_in); end
    step();
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL mid_rx_stays_empty: got %b want 0", rx_valid); end
  endtask

  initial begin
    s_zero = 1'b0;
    s_zero16 = '0;
    test_reset();
    test_loopback();
    test_tx_full();
    test_rx_filter();
    test_rx_overflow();
    test_underflow_sat();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
